// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: RISC-V load/store sizes,
// controller states and the access legality rule.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } dmem_state_e;

    // True when a request of this size at this byte offset must be rejected.
    function automatic logic access_bad(input logic [2:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_B, SZ_BU: bad = 1'b0;
            SZ_H, SZ_HU: bad = lane[0];
            SZ_W:        bad = (lane != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// CPU-side load/store bus of the data memory; the datapath is the master.
interface data_memory_bytelane_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  mem_size;
    logic [31:0] read_data;
    logic        read_valid;
    logic        misaligned;
    logic        ready;

    modport master (
        output addr, write_data, MemRead, MemWrite, mem_size,
        input  read_data, read_valid, misaligned, ready
    );

    modport slave (
        input  addr, write_data, MemRead, MemWrite, mem_size,
        output read_data, read_valid, misaligned, ready
    );
endinterface

// File: rtl/dmem_load_extract.sv
// Selects the addressed byte/half from a registered word and applies
// sign or zero extension according to the load size.
module dmem_load_extract
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*lane_i +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   data_o = {24'h0, byte_sel};
            SZ_H:    data_o = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory with B/H/W loads and stores, misalignment rejection
// and an optional post-reset zeroing sweep before requests are accepted.
module data_memory_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    data_memory_bytelane_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    dmem_state_e   state_q;
    logic [AW-1:0] clr_q;
    logic [31:0]   word_q;
    logic [1:0]    lane_q;
    logic [2:0]    size_q;
    logic          read_valid_q;
    logic          misaligned_q;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          req;
    logic          bad;
    logic          we_d;
    logic [3:0]    strb_d;
    logic [31:0]   wdata_d;
    logic [AW-1:0] widx_d;
    logic          unused_addr;

    assign idx         = bus.addr[AW+1:2];
    assign lane        = bus.addr[1:0];
    assign req         = bus.MemRead | bus.MemWrite;
    assign bad         = access_bad(bus.mem_size, lane);
    assign unused_addr = ^bus.addr[31:AW+2];

    // Write port is shared between the clear sweep and accepted stores;
    // store data is replicated across lanes so the strobe alone picks the bytes.
    always_comb begin
        we_d    = 1'b0;
        strb_d  = 4'h0;
        wdata_d = 32'h0;
        widx_d  = idx;
        if (state_q == ST_CLEAR) begin
            we_d   = 1'b1;
            strb_d = 4'hF;
            widx_d = clr_q;
        end else if (bus.MemWrite && !bad) begin
            we_d = 1'b1;
            case (bus.mem_size)
                SZ_B, SZ_BU: begin
                    strb_d  = 4'b0001 << lane;
                    wdata_d = {4{bus.write_data[7:0]}};
                end
                SZ_H, SZ_HU: begin
                    strb_d  = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{bus.write_data[15:0]}};
                end
                default: begin
                    strb_d  = 4'hF;
                    wdata_d = bus.write_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we_d) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_d[b]) mem_q[widx_d][8*b +: 8] <= wdata_d[8*b +: 8];
            end
        end
    end

    // The raw word is registered and extended afterwards, so a load costs one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_q        <= '0;
            word_q       <= 32'h0;
            lane_q       <= 2'b00;
            size_q       <= SZ_W;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_q <= clr_q + AW'(1);
                    if (clr_q == AW'(DEPTH - 1)) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req && bad) begin
                        misaligned_q <= 1'b1;
                    end else if (bus.MemRead) begin
                        read_valid_q <= 1'b1;
                        word_q       <= mem_q[idx];
                        lane_q       <= lane;
                        size_q       <= bus.mem_size;
                    end
                end
            endcase
        end
    end

    dmem_load_extract u_extract (
        .word_i (word_q),
        .lane_i (lane_q),
        .size_i (size_q),
        .data_o (bus.read_data)
    );

    assign bus.read_valid = read_valid_q;
    assign bus.misaligned = misaligned_q;
    assign bus.ready      = (state_q == ST_IDLE);
endmodule
